uart_rx_8n1: RTL
================

// Module: uart_rx_8n1
// PURPOSE
//   8N1 UART receiver, the RX partner of the MCU serial TX path. Samples asynchronous RXD
//   at mid-bit using the same per-bit clock count (baud_rate_period_m1) the host programs into TX.
//   Delivers each received byte to the host register file with valid, pending, framing-error
//   and overrun status.
// PARAMETERS
//   STABLE_TIME       `UART_STABLE_COUNT                 clk cycles RXD must stay high after reset before any start bit is accepted
//   BAUD_PERIOD_BITS  $clog2(`UART_TX_BAUD_PERIOD)       width of baud_rate_period_m1; RX and TX share the baud setting
// PORTS
//   clk                  in   1    system clock; the only clock
//   reset_n              in   1    asynchronous reset, active low
//   sync_reset           in   1    synchronous reset; same effect as reset_n, applied at the clk edge
//   baud_rate_period_m1  in   BPB  clocks per bit minus 1; static while a frame is in progress
//   RXD                  in   1    serial input, asynchronous, idle high
//   rx_clear             in   1    host acknowledge; clears rx_pending
//   SBUF_out             out  8    last good received byte
//   rx_valid             out  1    1-cycle pulse when SBUF_out is updated
//   rx_pending           out  1    set with rx_valid; cleared by rx_clear
//   framing_error        out  1    1-cycle pulse when the stop bit is sampled as 0
//   overrun_error        out  1    1-cycle pulse when a good byte lands while rx_pending=1
//   rx_active            out  1    1 whenever FSM is not in S_IDLE
// BEHAVIOUR
//   Reset (reset_n low or sync_reset): every output is 0; FSM goes to S_IDLE; line_ready=0; all counters are 0.
//   Input sync: RXD passes through 2 flops to give rxd_s. All decisions use rxd_s only. The sync adds 2 cycles of latency.
//   line_ready: stable_counter increments while rxd_s=1 and clears on rxd_s=0. When it reaches STABLE_TIME,
//     line_ready is set. It stays set until the next reset.
//   bit_timer: a BPB-bit counter. It clears on entry to every state. Otherwise it increments by 1 and wraps at
//     baud_rate_period_m1. half = baud_rate_period_m1 >> 1 (floor).
//   FSM states, one-hot: S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH.
//     S_IDLE:      line_ready & rxd_s=0 -> S_START.
//     S_START:     at bit_timer==half, sample rxd_s.
//                    0 -> S_DATA, bit_cnt=0.
//                    1 -> glitch; return to S_IDLE with no status.
//     S_DATA:      each bit_timer==baud_rate_period_m1 does shift={rxd_s,shift[7:1]} (LSB first) and bit_cnt+1.
//                  After the 8th sample -> S_STOP.
//     S_STOP:      at bit_timer==baud_rate_period_m1, sample the stop bit.
//                    1 -> next cycle: SBUF_out<=shift, rx_valid=1, rx_pending=1.
//                         overrun_error=1 if rx_pending was already 1. Then -> S_IDLE.
//                    0 -> next cycle: framing_error=1; SBUF_out and rx_pending unchanged. Then -> S_WAIT_HIGH.
//     S_WAIT_HIGH: rxd_s=1 -> S_IDLE. This handles a break or stuck-low line; no further status pulses.
//   Mid-bit sampling: samples land half+1 clocks after the synced falling edge, then every period_m1+1 clocks.
//   rx_clear and rx_valid in the same cycle: set wins, so rx_pending=1.
//   Back-to-back frames: the FSM returns to S_IDLE mid stop bit. The next start edge is accepted with no idle gap;
//     line_ready is not re-checked.
//   Reset mid-frame: the partial byte is discarded and SBUF_out clears to 0.
// STRUCTURE
//   Shared package / common.vh: state index localparams, UART_DATA_BITS=8, UART frame constants shared with TX.
//   One natural sub-module: uart_rx_sync, the 2-flop RXD synchronizer with reset-high output.
//   Everything else stays inline: stable_counter, bit_timer, bit_cnt[3:0], shift[7:0], the FSM comb/reg pair.
// TESTING  (baud_rate_period_m1=9 i.e. 10 clk/bit, STABLE_TIME=16)
//   1 Hold RXD=1 for 20 clk, then send 0xA5
//       -> one rx_valid pulse, SBUF_out=0xA5, rx_pending=1, both error pulses 0.
//   2 After line_ready, drive RXD low for 3 clk then high
//       -> rx_active pulses about 5 clk then returns to idle; no rx_valid; SBUF_out unchanged.
//   3 Send 0x3C with stop bit=0, hold low 50 clk, then send 0x5A
//       -> framing_error once, SBUF_out stays at old value, FSM in S_WAIT_HIGH until high;
//          then 0x5A is received correctly.
//   4 Send 0x01 then 0xFF back-to-back with no rx_clear
//       -> second frame gives rx_valid together with overrun_error, SBUF_out=0xFF.
//       Then pulse rx_clear -> rx_pending=0.
//   5 Send a start bit 5 clk after reset release, before line_ready -> ignored, no rx_active.
//   6 Assert sync_reset at data bit 4 of a frame
//       -> all outputs 0 on the next clk; after line_ready the next frame 0x77 is received correctly.

Source files
------------

// File: rtl/uart_rx_8n1_pkg.sv
// Shared constants and types for the 8N1 UART receiver.
// Frame levels and the baud setting match the TX side of the serial path.
package uart_rx_8n1_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_STABLE_COUNT   = 16;
    localparam int UART_TX_BAUD_PERIOD = 1024;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    localparam int S_IDLE_IDX      = 0;
    localparam int S_START_IDX     = 1;
    localparam int S_DATA_IDX      = 2;
    localparam int S_STOP_IDX      = 3;
    localparam int S_WAIT_HIGH_IDX = 4;

    typedef enum logic [4:0] {
        S_IDLE      = 5'(1 << S_IDLE_IDX),
        S_START     = 5'(1 << S_START_IDX),
        S_DATA      = 5'(1 << S_DATA_IDX),
        S_STOP      = 5'(1 << S_STOP_IDX),
        S_WAIT_HIGH = 5'(1 << S_WAIT_HIGH_IDX)
    } rx_state_e;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Host-side status/acknowledge bundle of the UART receiver.
// The receiver uses the master view; the host register file uses the slave view.
interface uart_rx_8n1_if;
    import uart_rx_8n1_pkg::*;

    logic                      rx_clear;
    logic [UART_DATA_BITS-1:0] SBUF_out;
    logic                      rx_valid;
    logic                      rx_pending;
    logic                      framing_error;
    logic                      overrun_error;
    logic                      rx_active;

    modport master (
        input  rx_clear,
        output SBUF_out, rx_valid, rx_pending, framing_error, overrun_error, rx_active
    );

    modport slave (
        output rx_clear,
        input  SBUF_out, rx_valid, rx_pending, framing_error, overrun_error, rx_active
    );

endinterface

// File: rtl/uart_rx_8n1_sync.sv
// Two-flop synchronizer for the asynchronous RXD line.
// Resets to the idle (high) level so a reset never looks like a start bit.
module uart_rx_8n1_sync
    import uart_rx_8n1_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic sync_reset,
    input  logic rxd_i,
    output logic rxd_s_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {2{UART_IDLE_LEVEL}};
        end else if (sync_reset) begin
            sync_q <= {2{UART_IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end

    assign rxd_s_o = sync_q[1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling of synchronized RXD, byte delivery to the
// host with valid/pending/framing-error/overrun status.
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int STABLE_TIME      = UART_STABLE_COUNT,
    parameter int BAUD_PERIOD_BITS = $clog2(UART_TX_BAUD_PERIOD)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sync_reset,
    input  logic [BAUD_PERIOD_BITS-1:0] baud_rate_period_m1,
    input  logic                        RXD,
    uart_rx_8n1_if.master               host
);

    localparam int SCW = $clog2(STABLE_TIME + 1);
    localparam logic [3:0] LAST_BIT = 4'(UART_DATA_BITS - 1);

    logic                        rxd_s;
    logic [SCW-1:0]              stable_cnt_q;
    logic                        line_ready_q;
    logic [BAUD_PERIOD_BITS-1:0] bit_timer_q;
    logic [3:0]                  bit_cnt_q;
    logic [UART_DATA_BITS-1:0]   shift_q;
    rx_state_e                   state_q, state_d;
    logic [UART_DATA_BITS-1:0]   sbuf_q, sbuf_d;
    logic                        valid_q, valid_d;
    logic                        pending_q, pending_d;
    logic                        ferr_q, ferr_d;
    logic                        ovr_q, ovr_d;
    logic                        at_half, at_end;

    uart_rx_8n1_sync u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (sync_reset),
        .rxd_i      (RXD),
        .rxd_s_o    (rxd_s)
    );

    assign at_half = (bit_timer_q == (baud_rate_period_m1 >> 1));
    assign at_end  = (bit_timer_q == baud_rate_period_m1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else if (sync_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (line_ready_q && rxd_s == UART_START_LEVEL) state_d = S_START;
            S_START:     if (at_half) state_d = (rxd_s == UART_START_LEVEL) ? S_DATA : S_IDLE;
            S_DATA:      if (at_end && bit_cnt_q == LAST_BIT) state_d = S_STOP;
            S_STOP:      if (at_end) state_d = (rxd_s == UART_STOP_LEVEL) ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rxd_s == UART_IDLE_LEVEL) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // A good stop bit sets pending in the same cycle a host clear would drop it; set wins.
    always_comb begin
        sbuf_d    = sbuf_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        pending_d = pending_q & ~host.rx_clear;
        if (state_q == S_STOP && at_end) begin
            if (rxd_s == UART_STOP_LEVEL) begin
                sbuf_d    = shift_q;
                valid_d   = 1'b1;
                ovr_d     = pending_q;
                pending_d = 1'b1;
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt_q <= '0;
            line_ready_q <= 1'b0;
            bit_timer_q  <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            sbuf_q       <= '0;
            valid_q      <= 1'b0;
            pending_q    <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else if (sync_reset) begin
            stable_cnt_q <= '0;
            line_ready_q <= 1'b0;
            bit_timer_q  <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            sbuf_q       <= '0;
            valid_q      <= 1'b0;
            pending_q    <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            if (rxd_s != UART_IDLE_LEVEL) begin
                stable_cnt_q <= '0;
            end else if (stable_cnt_q != SCW'(STABLE_TIME)) begin
                stable_cnt_q <= stable_cnt_q + SCW'(1);
            end
            if (stable_cnt_q == SCW'(STABLE_TIME)) line_ready_q <= 1'b1;

            if (state_d != state_q || at_end) begin
                bit_timer_q <= '0;
            end else begin
                bit_timer_q <= bit_timer_q + BAUD_PERIOD_BITS'(1);
            end

            if (state_q == S_START) begin
                bit_cnt_q <= '0;
            end else if (state_q == S_DATA && at_end) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                shift_q   <= {rxd_s, shift_q[UART_DATA_BITS-1:1]};
            end

            sbuf_q    <= sbuf_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign host.SBUF_out      = sbuf_q;
    assign host.rx_valid      = valid_q;
    assign host.rx_pending    = pending_q;
    assign host.framing_error = ferr_q;
    assign host.overrun_error = ovr_q;
    assign host.rx_active     = (state_q != S_IDLE);

endmodule
